// File: rtl/uart_tx_engine.sv
// UART transmit engine: THR/TSR pair plus a bit-timing FSM that serialises one
// character per frame onto txd using the oversampled baud clock.
module uart_tx_engine #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned MAX_BITS   = 8
) (
    input  logic                BCLK,
    input  logic                RST_N,
    input  logic                thr_wr,
    input  logic [MAX_BITS-1:0] thr_data,
    input  logic [7:0]          lcr,
    output logic                txd,
    output logic                thr_empty,
    output logic                tsr_empty,
    output logic                tx_done,
    output logic                thr_ovr
);

    localparam int unsigned TICK_W = $clog2(2 * OVERSAMPLE);
    localparam int unsigned BIT_W  = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP1_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP15_LAST = TICK_W'((OVERSAMPLE * 3) / 2 - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST = TICK_W'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [MAX_BITS-1:0] tsr_q, tsr_d;
    logic [MAX_BITS-1:0] thr_q, thr_d;
    logic [1:0]          wl_q, wl_d;
    logic                stb_q, stb_d;
    logic                pen_q, pen_d;
    logic                par_q, par_d;

    logic                thr_empty_d;
    logic                tsr_empty_d;
    logic                tx_done_d;
    logic                thr_ovr_d;
    logic                txd_d;

    logic                transfer;
    logic                wr_accept;
    logic                line;
    logic                bit_end;
    logic [TICK_W-1:0]   stop_last;
    logic [BIT_W-1:0]    data_last;
    logic                unused_lcr;

    assign unused_lcr = lcr[7];

    // Parity over the low (5 + wl) bits of a character.
    function automatic logic calc_par(input logic [MAX_BITS-1:0] d, input logic [1:0] wl);
        logic p;
        p = 1'b0;
        for (int i = 0; i < int'(MAX_BITS); i++) begin
            if (i < 5 + int'(wl)) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

    assign bit_end   = (tick_q == BIT_LAST);
    assign data_last = BIT_W'(4) + BIT_W'(wl_q);
    assign stop_last = !stb_q ? STOP1_LAST : ((wl_q == 2'b00) ? STOP15_LAST : STOP2_LAST);

    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            tsr_q     <= '0;
            thr_q     <= '0;
            wl_q      <= '0;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            txd       <= 1'b1;
            thr_empty <= 1'b1;
            tsr_empty <= 1'b1;
            tx_done   <= 1'b0;
            thr_ovr   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            tsr_q     <= tsr_d;
            thr_q     <= thr_d;
            wl_q      <= wl_d;
            stb_q     <= stb_d;
            pen_q     <= pen_d;
            par_q     <= par_d;
            txd       <= txd_d;
            thr_empty <= thr_empty_d;
            tsr_empty <= tsr_empty_d;
            tx_done   <= tx_done_d;
            thr_ovr   <= thr_ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q + TICK_W'(1);
        bit_d    = bit_q;
        tsr_d    = tsr_q;
        wl_d     = wl_q;
        stb_d    = stb_q;
        pen_d    = pen_q;
        par_d    = par_q;
        transfer = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!thr_empty) begin
                    transfer = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tick_d = '0;
                    if (bit_q == data_last) begin
                        bit_d   = '0;
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tsr_d = tsr_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick_q == stop_last) begin
                    tick_d = '0;
                    if (!thr_empty) begin
                        transfer = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Frame format and parity bit are frozen when the character leaves THR.
        if (transfer) begin
            tsr_d = thr_q;
            wl_d  = lcr[1:0];
            stb_d = lcr[2];
            pen_d = lcr[3];
            par_d = lcr[5] ? ~lcr[4] : (lcr[4] ? calc_par(thr_q, lcr[1:0])
                                               : ~calc_par(thr_q, lcr[1:0]));
        end

        wr_accept   = thr_wr && (thr_empty || transfer);
        thr_d       = wr_accept ? thr_data : thr_q;
        thr_empty_d = wr_accept ? 1'b0 : (transfer ? 1'b1 : thr_empty);
        thr_ovr_d   = thr_wr && !wr_accept;

        case (state_d)
            ST_START:  line = 1'b0;
            ST_DATA:   line = tsr_d[0];
            ST_PARITY: line = par_q;
            default:   line = 1'b1;
        endcase
        if (transfer) begin
            line = 1'b0;
        end

        txd_d       = lcr[6] ? 1'b0 : line;
        tx_done_d   = (state_d == ST_STOP) && (tick_d == stop_last);
        tsr_empty_d = (state_d == ST_IDLE) && thr_empty_d;
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: characters are queued at write time and a
// frame receiver pops and checks them cycle by cycle against a line model.
module tb_uart_tx_engine;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] cfg;
    } item_t;

    logic       BCLK = 1'b0;
    logic       RST_N;
    logic       thr_wr;
    logic [7:0] thr_data;
    logic [7:0] lcr;
    logic       txd;
    logic       thr_empty;
    logic       tsr_empty;
    logic       tx_done;
    logic       thr_ovr;

    item_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    d0;
    int    d1;
    logic  par_seen;
    logic  ok;

    uart_tx_engine #(.OVERSAMPLE(OS), .MAX_BITS(8)) dut (
        .BCLK      (BCLK),
        .RST_N     (RST_N),
        .thr_wr    (thr_wr),
        .thr_data  (thr_data),
        .lcr       (lcr),
        .txd       (txd),
        .thr_empty (thr_empty),
        .tsr_empty (tsr_empty),
        .tx_done   (tx_done),
        .thr_ovr   (thr_ovr)
    );

    always #5 BCLK = ~BCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 time unit after the rising edge; drivers use +2.
    task automatic step();
        @(posedge BCLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit push);
        @(posedge BCLK);
        #2;
        thr_wr   = 1'b1;
        thr_data = d;
        if (push) exp_q.push_back('{data: d, cfg: lcr});
        @(posedge BCLK);
        #2;
        thr_wr = 1'b0;
    endtask

    // Called at the first START cycle; returns the frame cycle carrying tx_done.
    task automatic recv_frame(input string tag, output int done_at, output logic par_s);
        item_t      it;
        int         n;
        int         pen;
        int         nbits;
        int         stop_len;
        int         plen;
        int         cyc;
        int         dcount;
        logic [7:0] mask;
        logic [15:0] line;
        logic       p;
        logic       expt;
        logic       bit_ok;
        done_at = -1;
        par_s   = 1'bx;
        chk({tag, " pending"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() == 0) return;
        it       = exp_q.pop_front();
        n        = 5 + int'(it.cfg[1:0]);
        pen      = int'(it.cfg[3]);
        nbits    = 1 + n + pen;
        stop_len = !it.cfg[2] ? OS : ((it.cfg[1:0] == 2'b00) ? (OS * 3) / 2 : 2 * OS);
        mask     = 8'((1 << n) - 1);
        p        = ^(it.data & mask);
        line     = '0;
        for (int i = 0; i < n; i++) line[1 + i] = it.data[i];
        if (pen != 0) line[1 + n] = it.cfg[5] ? ~it.cfg[4] : (it.cfg[4] ? p : ~p);
        cyc    = 0;
        dcount = 0;
        for (int b = 0; b <= nbits; b++) begin
            plen   = (b < nbits) ? OS : stop_len;
            bit_ok = 1'b1;
            for (int k = 0; k < plen; k++) begin
                if (cyc != 0) step();
                expt = lcr[6] ? 1'b0 : ((b < nbits) ? line[b] : 1'b1);
                if (txd !== expt) bit_ok = 1'b0;
                if (pen != 0 && b == 1 + n && k == OS / 2) par_s = txd;
                if (tx_done === 1'b1) begin
                    dcount++;
                    if (done_at < 0) done_at = cyc;
                end
                cyc++;
            end
            chk($sformatf("%s bit%0d", tag, b), 32'(bit_ok), 1);
        end
        chk({tag, " tx_done pulses"}, dcount, 1);
    endtask

    initial begin
        RST_N    = 1'b0;
        thr_wr   = 1'b0;
        thr_data = 8'h00;
        lcr      = 8'h03;
        repeat (3) step();
        chk("reset txd", txd, 1);
        chk("reset thr_empty", thr_empty, 1);
        chk("reset tsr_empty", tsr_empty, 1);
        chk("reset tx_done", tx_done, 0);
        chk("reset thr_ovr", thr_ovr, 0);
        #1 RST_N = 1'b1;
        repeat (2) step();

        // 8N1, 0xA5
        wr(8'hA5, 1);
        chk("8N1 thr_empty W+1", thr_empty, 0);
        chk("8N1 tsr_empty W+1", tsr_empty, 0);
        step();
        chk("8N1 txd W+2", txd, 0);
        chk("8N1 thr_empty W+2", thr_empty, 1);
        recv_frame("8N1", d0, par_seen);
        chk("8N1 tx_done cycle", d0, 159);
        step();
        chk("8N1 tsr_empty after", tsr_empty, 1);
        chk("8N1 txd idle", txd, 1);

        // 7-bit parity variants on 0x53
        lcr = 8'h1A;
        wr(8'h53, 1);
        step();
        recv_frame("7E1", d0, par_seen);
        chk("7E1 parity bit", par_seen, 0);
        step();
        lcr = 8'h0A;
        wr(8'h53, 1);
        step();
        recv_frame("7O1", d0, par_seen);
        chk("7O1 parity bit", par_seen, 1);
        step();
        lcr = 8'h3A;
        wr(8'h53, 1);
        step();
        recv_frame("7S1", d0, par_seen);
        chk("7 stick parity bit", par_seen, 0);
        step();

        // Long stop bits
        lcr = 8'h04;
        wr(8'h1F, 1);
        step();
        recv_frame("5N1.5", d0, par_seen);
        chk("5-bit STB frame end", d0, 119);
        step();
        lcr = 8'h07;
        wr(8'hC3, 1);
        step();
        recv_frame("8N2", d0, par_seen);
        chk("8-bit STB frame end", d0, 175);
        step();

        // Back-to-back with an overrun
        lcr = 8'h03;
        wr(8'h11, 1);
        step();
        fork
            recv_frame("b2b first", d1, par_seen);
            begin
                repeat (40) @(posedge BCLK);
                wr(8'h22, 1);
                chk("b2b second write held", thr_empty, 0);
                repeat (20) @(posedge BCLK);
                wr(8'h33, 0);
                chk("b2b thr_ovr pulse", thr_ovr, 1);
                @(posedge BCLK);
                #2;
                chk("b2b thr_ovr one cycle", thr_ovr, 0);
            end
        join
        chk("b2b first tx_done cycle", d1, 159);
        step();
        chk("b2b second start txd", txd, 0);
        chk("b2b thr_empty after transfer", thr_empty, 1);
        recv_frame("b2b second", d0, par_seen);
        chk("b2b second tx_done cycle", d0, 159);
        step();
        chk("b2b tsr_empty after", tsr_empty, 1);

        // Break mid-frame
        wr(8'h5A, 1);
        step();
        fork
            recv_frame("break", d0, par_seen);
            begin
                repeat (50) @(posedge BCLK);
                #2 lcr[6] = 1'b1;
                repeat (20) @(posedge BCLK);
                #2;
                chk("break txd low", txd, 0);
                repeat (20) @(posedge BCLK);
                #2 lcr[6] = 1'b0;
            end
        join
        chk("break tx_done cycle", d0, 159);
        step();
        chk("break tsr_empty after", tsr_empty, 1);

        // Reset mid-DATA
        wr(8'h00, 0);
        step();
        repeat (50) step();
        chk("pre-reset txd", txd, 0);
        #1 RST_N = 1'b0;
        #1;
        chk("async reset txd", txd, 1);
        chk("async reset thr_empty", thr_empty, 1);
        chk("async reset tsr_empty", tsr_empty, 1);
        repeat (2) step();
        #1 RST_N = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            step();
            if (txd !== 1'b1 || tsr_empty !== 1'b1) ok = 1'b0;
        end
        chk("idle after reset", 32'(ok), 1);
        wr(8'h96, 1);
        step();
        recv_frame("post-reset", d0, par_seen);
        chk("post-reset tx_done cycle", d0, 159);
        step();
        chk("post-reset tsr_empty", tsr_empty, 1);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
